// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame geometry.
// The frame geometry is common to the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side holding register handshake plus error event pulses.
// master = receiver (producer), slave = memory-mapped IO logic (consumer).
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    output frame_err,
    output overrun,
    output parity_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    input  frame_err,
    input  overrun,
    input  parity_err
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so idle-high lines do not look active coming out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN defined), mid-bit
// sampling, valid/ready holding register, single-cycle error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      rxd,
  uart_rx_if.master rx_bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

  logic                 rxd_s;
  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 bit_tick;
  logic                 half_tick;
  logic                 stop_sample;
  logic                 frame_ok;
  logic                 consume;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rxd),
    .q      (rxd_s)
  );

  assign bit_tick    = (cnt == BIT_LAST);
  assign half_tick   = (cnt == HALF_LAST);
  assign stop_sample = (state == ST_STOP) && bit_tick;
  assign consume     = valid_q && rx_bus.rx_ready;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (!rxd_s) next_state = ST_START;
      ST_START:     if (half_tick) next_state = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (bit_tick && (bit_idx == IDX_LAST)) next_state = ST_AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      ST_PARITY:    if (bit_tick) next_state = ST_STOP;
`endif
      ST_STOP:      if (bit_tick) next_state = rxd_s ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rxd_s) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Counter restarts on every state change so each state times from its own entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        cnt <= '0;
      else if ((state == ST_IDLE) || (state == ST_WAIT_HIGH) || bit_tick)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if ((state == ST_START) && half_tick)
        bit_idx <= '0;
      else if ((state == ST_DATA) && bit_tick) begin
        shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
        bit_idx   <= bit_idx + 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bad;
  logic parity_err_q;

  // Mismatch is remembered until the stop sample so all error pulses line up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parity_bad   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      if ((state == ST_PARITY) && bit_tick)
        parity_bad <= (rxd_s != (^shift_reg));
      if (stop_sample)
        parity_err_q <= parity_bad;
    end
  end

  assign frame_ok          = stop_sample && rxd_s && !parity_bad;
  assign rx_bus.parity_err = parity_err_q;
`else
  assign frame_ok          = stop_sample && rxd_s;
  assign rx_bus.parity_err = 1'b0;
`endif

  // A completing frame wins over a pure consume; a full, unconsumed register drops it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_sample && !rxd_s;
      overrun_q   <= 1'b0;
      if (frame_ok) begin
        if (!valid_q || rx_bus.rx_ready) begin
          data_q  <= shift_reg;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (consume) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_data   = data_q;
  assign rx_bus.rx_valid  = valid_q;
  assign rx_bus.frame_err = frame_err_q;
  assign rx_bus.overrun   = overrun_q;

endmodule
